ovl_win_seq_ctrl: RTL and testbench

//  Sequencer that drives the stimulus side of a window-stability checker
//  (ovl_win_unchange style).

---
 rtl/ovl_win_seq_pkg.sv | 28 ++
 rtl/ovl_win_seq_cnt.sv | 29 ++
 rtl/ovl_win_seq_ctrl.sv | 111 +++++++++++
 tb/tb_ovl_win_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ovl_win_seq_pkg.sv
// Shared types and default sizing for the window-stability stimulus sequencer.
// Optional feature macro used by the top: OVL_WIN_SEQ_GLITCH_EN.
package ovl_win_seq_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_GAP_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_HOLD  = 3'd2,
    ST_END   = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] data;
    logic [DEF_LEN_W-1:0] len;
    logic [DEF_GAP_W-1:0] gap;
    logic                 glitch;
  } cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ovl_win_seq_cnt.sv
// Loadable saturating down-counter shared by the HOLD and GAP phases.
module ovl_win_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         is_one_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign is_one_o = (cnt_q == W'(1));

endmodule

// File: rtl/ovl_win_seq_ctrl.sv
// Window sequencer: start pulse, hold test_expr for len cycles, end pulse, gap.
// Define OVL_WIN_SEQ_GLITCH_EN to allow a one-cycle LSB flip on the first HOLD cycle.
module ovl_win_seq_ctrl
  import ovl_win_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [GAP_W-1:0] cmd_gap_i,
  input  logic             cmd_glitch_i,
  output logic             start_event_o,
  output logic             end_event_o,
  output logic [WIDTH-1:0] test_expr_o,
  output logic             win_active_o,
  output logic             done_o
);

  localparam int CNT_W = max_int(LEN_W, GAP_W);

`ifdef OVL_WIN_SEQ_GLITCH_EN
  localparam logic GLITCH_EN = 1'b1;
`else
  localparam logic GLITCH_EN = 1'b0;
`endif

  state_t state_q, state_d;
  logic             ready_q, done_q, first_hold_q;
  logic [WIDTH-1:0] data_q;
  logic [LEN_W-1:0] len_q;
  logic [GAP_W-1:0] gap_q;
  logic             glitch_q;

  logic             accept;
  logic             cnt_load, cnt_dec, cnt_is_one;
  logic [CNT_W-1:0] cnt_val;
  logic             in_window, flip;

  // ready_q is registered so it stays low until the first edge after reset.
  assign accept = cmd_valid_i & ready_q;

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = (len_q != '0) ? ST_HOLD : ST_END;
      ST_HOLD:  if (cnt_is_one) state_d = ST_END;
      ST_END:   state_d = (gap_q != '0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (cnt_is_one) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      first_hold_q <= 1'b0;
      data_q       <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      glitch_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= (state_d == ST_IDLE);
      done_q       <= (state_q == ST_END);
      first_hold_q <= (state_q == ST_START);
      if (accept) begin
        data_q   <= cmd_data_i;
        len_q    <= cmd_len_i;
        gap_q    <= cmd_gap_i;
        glitch_q <= cmd_glitch_i;
      end
    end
  end

  // Loading one cycle ahead makes the counter read len (or gap) on the first
  // HOLD (or GAP) cycle; the phase ends on the cycle it reads 1.
  assign cnt_load = (state_q == ST_START) || (state_q == ST_END);
  assign cnt_val  = (state_q == ST_START) ? CNT_W'(len_q) : CNT_W'(gap_q);
  assign cnt_dec  = (state_q == ST_HOLD) || (state_q == ST_GAP);

  ovl_win_seq_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (cnt_load),
    .val_i    (cnt_val),
    .dec_i    (cnt_dec),
    .is_one_o (cnt_is_one)
  );

  assign in_window = (state_q == ST_START) || (state_q == ST_HOLD) || (state_q == ST_END);
  assign flip      = GLITCH_EN & glitch_q & first_hold_q & (state_q == ST_HOLD);

  assign cmd_ready_o   = ready_q;
  assign start_event_o = (state_q == ST_START);
  assign end_event_o   = (state_q == ST_END);
  assign win_active_o  = in_window;
  assign test_expr_o   = in_window ? (data_q ^ WIDTH'(flip)) : '0;
  assign done_o        = done_q;

endmodule

// File: tb/tb_ovl_win_seq_ctrl.sv
// Self-checking bench: command-table runs, reset/back-pressure sequences and
// random traffic compared against a timeline model of the window schedule.
module tb_ovl_win_seq_ctrl;

`ifdef OVL_WIN_SEQ_GLITCH_EN
  localparam bit GL_EN = 1'b1;
`else
  localparam bit GL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = '0;
  logic [3:0] cmd_len = '0;
  logic [2:0] cmd_gap = '0;
  logic       cmd_glitch = 1'b0;
  logic       start_event, end_event, win_active, done;
  logic [3:0] test_expr;

  always #5 clk = ~clk;

  ovl_win_seq_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_data_i    (cmd_data),
    .cmd_len_i     (cmd_len),
    .cmd_gap_i     (cmd_gap),
    .cmd_glitch_i  (cmd_glitch),
    .start_event_o (start_event),
    .end_event_o   (end_event),
    .test_expr_o   (test_expr),
    .win_active_o  (win_active),
    .done_o        (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: outputs are a pure function of the offset from the
  // last accepted command.
  int         cyc = 0;
  bit         m_rst = 1'b1;
  bit         m_have = 1'b0;
  int         m_c, m_l, m_g;
  logic [3:0] m_d;
  bit         m_gl;

  function automatic logic [8:0] model_out();
    logic st, en, wa, dn, rdy;
    logic [3:0] te;
    int k;
    st = 0; en = 0; wa = 0; dn = 0; rdy = 0; te = '0;
    if (!m_rst) begin
      rdy = 1'b1;
      if (m_have) begin
        k   = cyc - m_c;
        st  = (k == 1);
        en  = (k == m_l + 2);
        wa  = (k >= 1) && (k <= m_l + 2);
        dn  = (k == m_l + 3);
        rdy = (k >= m_l + 3 + m_g);
        if (wa) te = (GL_EN && m_gl && m_l >= 1 && k == 2) ? (m_d ^ 4'h1) : m_d;
      end
    end
    return {st, en, wa, dn, rdy, te};
  endfunction

  // Observation of event offsets for the table-driven runs and T6.
  bit         obs_on = 1'b0;
  int         obs_c, obs_start, obs_end, obs_done, obs_ready;
  logic [3:0] obs_k2;
  bit         t6_on = 1'b0;
  int         starts[$];

  task automatic check_all();
    int k;
    check($sformatf("outs_cyc%0d", cyc),
          {23'd0, start_event, end_event, win_active, done, cmd_ready, test_expr},
          {23'd0, model_out()});
    if (start_event && end_event) check("start_end_overlap", 1, 0);
    if (obs_on && cyc > obs_c) begin
      k = cyc - obs_c;
      if (start_event && obs_start < 0) obs_start = k;
      if (end_event && obs_end < 0) obs_end = k;
      if (done && obs_done < 0) obs_done = k;
      if (cmd_ready && obs_ready < 0) obs_ready = k;
      if (k == 2) obs_k2 = test_expr;
    end
    if (t6_on && start_event) starts.push_back(cyc);
  endtask

  task automatic tick(input logic v, input logic [3:0] d, input int len, input int gap,
                      input logic gl);
    logic [8:0] e;
    @(negedge clk);
    check_all();
    e = model_out();
    cmd_valid  = v;
    cmd_data   = d;
    cmd_len    = 4'(len);
    cmd_gap    = 3'(gap);
    cmd_glitch = gl;
    if (!m_rst && v && e[4]) begin
      m_have = 1'b1; m_c = cyc; m_d = d; m_l = len; m_g = gap; m_gl = gl;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 0, 0, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    m_rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] data;
    int         len;
    int         gap;
    logic       glitch;
    int         exp_end;
    int         exp_done;
    int         exp_ready;
    logic [3:0] exp_k2;
  } vec_t;

  vec_t vecs[6];

  task automatic run_cmd(input vec_t v, input int idx);
    obs_start = -1; obs_end = -1; obs_done = -1; obs_ready = -1; obs_k2 = 'x;
    obs_c = cyc;
    obs_on = 1'b1;
    tick(1'b1, v.data, v.len, v.gap, v.glitch);
    for (int i = 0; i < 40 && obs_ready < 0; i++) tick(1'b0, 4'h0, 0, 0, 1'b0);
    obs_on = 1'b0;
    check($sformatf("v%0d_start", idx), obs_start, 1);
    check($sformatf("v%0d_end", idx),   obs_end,   v.exp_end);
    check($sformatf("v%0d_done", idx),  obs_done,  v.exp_done);
    check($sformatf("v%0d_ready", idx), obs_ready, v.exp_ready);
    check($sformatf("v%0d_k2", idx),    obs_k2,    v.exp_k2);
  endtask

  initial begin
    // data, len, gap, glitch, end@, done@, ready@, test_expr@C+2
    vecs[0] = '{4'h3, 4,  2, 1'b0, 6,  7,  9,  4'h3};
    vecs[1] = '{4'h9, 0,  0, 1'b0, 2,  3,  3,  4'h9};
    vecs[2] = '{4'h8, 3,  1, 1'b1, 5,  6,  7,  GL_EN ? 4'h9 : 4'h8};
    vecs[3] = '{4'h5, 15, 7, 1'b0, 17, 18, 25, 4'h5};
    vecs[4] = '{4'hA, 0,  7, 1'b1, 2,  3,  10, 4'hA};
    vecs[5] = '{4'hF, 1,  0, 1'b1, 3,  4,  4,  GL_EN ? 4'hE : 4'hF};

    // T1: reset state and release
    #1;
    check("reset_outs", {start_event, end_event, win_active, done, cmd_ready, test_expr}, 9'd0);
    @(posedge clk);
    @(posedge clk);
    release_reset();
    idle(3);

    // T2/T3/T4 and boundary lengths
    for (int i = 0; i < 6; i++) begin
      run_cmd(vecs[i], i);
      idle(1);
    end

    // T5: asynchronous reset in the middle of HOLD
    tick(1'b1, 4'h6, 10, 3, 1'b0);
    idle(4);
    #2;
    rst_n  = 1'b0;
    m_rst  = 1'b1;
    m_have = 1'b0;
    #1;
    check("async_reset_outs",
          {start_event, end_event, win_active, done, cmd_ready, test_expr}, 9'd0);
    idle(2);
    release_reset();
    idle(3);
    run_cmd(vecs[0], 10);

    // T6: valid held high continuously
    starts.delete();
    t6_on = 1'b1;
    for (int i = 0; i < 60; i++) tick(1'b1, 4'hC, 15, 7, 1'b0);
    t6_on = 1'b0;
    check("t6_starts", starts.size(), 3);
    if (starts.size() >= 3) begin
      check("t6_space0", starts[1] - starts[0], 25);
      check("t6_space1", starts[2] - starts[1], 25);
    end
    idle(30);

    // Random traffic, valid also offered while busy
    for (int i = 0; i < 800; i++) begin
      tick(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
